// File: rtl/config_pkg.sv
// Shared types and defaults for the DDR read path feeding matrix_unit.
package config_pkg;

   localparam int AddrW            = 32;
   localparam int DataW            = 32;
   localparam int FifoDepthDefault = 4;

   typedef logic [AddrW-1:0] ddr_addr_t;
   typedef logic [DataW-1:0] ddr_data_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FETCH,
      ST_DRAIN,
      ST_DONE
   } pf_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered read port: popped data appears the cycle after pop_i.
module sync_fifo #(
   parameter int Width = 32,
   parameter int Depth = 4
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   push_i,
   input  logic [Width-1:0]       wdata_i,
   input  logic                   pop_i,
   output logic [Width-1:0]       rdata_o,
   output logic                   full_o,
   output logic                   empty_o,
   output logic [$clog2(Depth):0] count_o
);

   localparam int PtrW = $clog2(Depth);
   localparam int CntW = PtrW + 1;

   logic [Width-1:0] r_mem [Depth];
   logic [PtrW-1:0]  r_wr_ptr;
   logic [PtrW-1:0]  r_rd_ptr;
   logic [CntW-1:0]  r_count;
   logic [Width-1:0] r_rdata;
   logic             w_push;
   logic             w_pop;

   assign full_o  = (r_count == CntW'(Depth));
   assign empty_o = (r_count == '0);
   assign count_o = r_count;
   assign rdata_o = r_rdata;
   assign w_push  = push_i && !full_o;
   assign w_pop   = pop_i && !empty_o;

   // NOTE: the storage array has no reset; pointers and count alone say which entries are valid.
   always_ff @(posedge clk_i) begin
      if (w_push) r_mem[r_wr_ptr] <= wdata_i;
   end

   // NOTE: non-blocking assignments so every flop samples the values from before the edge.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_rdata  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PtrW'(1);
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PtrW'(1);
            r_rdata  <= r_mem[r_rd_ptr];
         end
         r_count <= r_count + CntW'(w_push) - CntW'(w_pop);
      end
   end

endmodule

// File: rtl/ddr_read_prefetcher.sv
// Fetches a contiguous run of DDR words into a small FIFO; credits (outstanding + occupancy)
// bound the requests in flight so a response always has a free slot.
module ddr_read_prefetcher
   import config_pkg::*;
#(
   parameter int FifoDepth = FifoDepthDefault,
   parameter int NumWordsW = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 start_i,
   input  ddr_addr_t            base_addr_i,
   input  logic [NumWordsW-1:0] num_words_i,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 underflow_o,
   output logic                 ddr_req_o,
   output ddr_addr_t            ddr_req_addr_o,
   input  logic                 ddr_req_ready_i,
   input  logic                 ddr_rsp_valid_i,
   input  ddr_data_t            ddr_rsp_data_i,
   output logic                 r_avail_o,
   input  logic                 r_en_i,
   output ddr_data_t            r_data_o
);

   localparam int CntW = $clog2(FifoDepth) + 1;

   pf_state_e            r_state;
   pf_state_e            w_state_nxt;
   ddr_addr_t            r_addr;
   logic [NumWordsW-1:0] r_num_words;
   logic [NumWordsW-1:0] r_issued;
   logic [NumWordsW-1:0] r_consumed;
   logic [CntW-1:0]      r_outstanding;
   logic                 r_underflow;

   logic [CntW-1:0]      w_fifo_count;
   logic                 w_fifo_empty;
   logic                 w_fifo_full;
   logic                 w_start;
   logic                 w_credit_ok;
   logic                 w_req;
   logic                 w_accept;
   logic                 w_rsp_ok;
   logic                 w_pop;
   logic                 w_last_pop;
   logic                 w_err;

   // Credit uses registered counts only; a pop this cycle frees a slot from the next cycle.
   assign w_credit_ok = !w_fifo_full &&
                        (({1'b0, r_outstanding} + {1'b0, w_fifo_count}) < (CntW+1)'(FifoDepth));
   assign w_start     = (r_state == ST_IDLE) && start_i;
   assign w_req       = (r_state == ST_FETCH) && (r_issued < r_num_words) && w_credit_ok;
   assign w_accept    = w_req && ddr_req_ready_i;
   assign w_rsp_ok    = ddr_rsp_valid_i && (r_outstanding != '0);
   assign w_pop       = r_en_i && !w_fifo_empty;
   assign w_last_pop  = w_pop && ((r_consumed + NumWordsW'(1)) == r_num_words);
   assign w_err       = (r_en_i && w_fifo_empty) || (ddr_rsp_valid_i && (r_outstanding == '0));

   sync_fifo #(
      .Width ($bits(ddr_data_t)),
      .Depth (FifoDepth)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (w_rsp_ok),
      .wdata_i (ddr_rsp_data_i),
      .pop_i   (r_en_i),
      .rdata_o (r_data_o),
      .full_o  (w_fifo_full),
      .empty_o (w_fifo_empty),
      .count_o (w_fifo_count)
   );

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      w_state_nxt = r_state;
      busy_o      = 1'b1;
      done_o      = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            busy_o = 1'b0;
            if (start_i) w_state_nxt = (num_words_i == '0) ? ST_DONE : ST_FETCH;
         end
         ST_FETCH: begin
            if (w_last_pop)                    w_state_nxt = ST_DONE;
            else if (r_issued == r_num_words)  w_state_nxt = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (w_last_pop) w_state_nxt = ST_DONE;
         end
         ST_DONE: begin
            done_o      = 1'b1;
            w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state       <= ST_IDLE;
         r_addr        <= '0;
         r_num_words   <= '0;
         r_issued      <= '0;
         r_consumed    <= '0;
         r_outstanding <= '0;
         r_underflow   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_start) begin
            r_addr      <= base_addr_i;
            r_num_words <= num_words_i;
            r_issued    <= '0;
            r_consumed  <= '0;
         end else begin
            if (w_accept) begin
               r_addr   <= r_addr + ddr_addr_t'(1);
               r_issued <= r_issued + NumWordsW'(1);
            end
            if (w_pop) r_consumed <= r_consumed + NumWordsW'(1);
         end
         r_outstanding <= r_outstanding + CntW'(w_accept) - CntW'(w_rsp_ok);
         if (w_start)    r_underflow <= 1'b0;
         else if (w_err) r_underflow <= 1'b1;
      end
   end

   assign ddr_req_o      = w_req;
   assign ddr_req_addr_o = r_addr;
   assign underflow_o    = r_underflow;
   assign r_avail_o      = !w_fifo_empty;

endmodule

// File: tb/tb_ddr_read_prefetcher.sv
// Directed bench for ddr_read_prefetcher with a small in-order DDR model and an auto consumer.
module tb_ddr_read_prefetcher;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        start_i;
   logic [31:0] base_addr_i;
   logic [15:0] num_words_i;
   logic        busy_o;
   logic        done_o;
   logic        underflow_o;
   logic        ddr_req_o;
   logic [31:0] ddr_req_addr_o;
   logic        ddr_req_ready_i = 1'b0;
   logic        ddr_rsp_valid_i = 1'b0;
   logic [31:0] ddr_rsp_data_i  = '0;
   logic        r_avail_o;
   logic        r_en_i = 1'b0;
   logic [31:0] r_data_o;

   typedef struct {
      logic [31:0] addr;
      int          due;
   } pend_t;

   pend_t       pend[$];
   pend_t       ent;
   logic [31:0] req_log[$];
   int          n_checks      = 0;
   int          n_errors      = 0;
   int          cyc           = 0;
   int          n_req         = 0;
   int          words_seen    = 0;
   int          pop_cyc_last  = -1;
   int          lat_min       = 1;
   int          lat_max       = 1;
   logic        rdy_rand      = 1'b0;
   logic        cons_auto     = 1'b0;
   logic        man_ren       = 1'b0;
   logic        spur_rsp      = 1'b0;
   logic        pop_pending   = 1'b0;
   logic        stall_pending = 1'b0;
   logic [31:0] stall_addr    = '0;
   logic [31:0] exp_addr      = '0;

   ddr_read_prefetcher dut (
      .clk_i           (clk_i),
      .rst_ni          (rst_ni),
      .start_i         (start_i),
      .base_addr_i     (base_addr_i),
      .num_words_i     (num_words_i),
      .busy_o          (busy_o),
      .done_o          (done_o),
      .underflow_o     (underflow_o),
      .ddr_req_o       (ddr_req_o),
      .ddr_req_addr_o  (ddr_req_addr_o),
      .ddr_req_ready_i (ddr_req_ready_i),
      .ddr_rsp_valid_i (ddr_rsp_valid_i),
      .ddr_rsp_data_i  (ddr_rsp_data_i),
      .r_avail_o       (r_avail_o),
      .r_en_i          (r_en_i),
      .r_data_o        (r_data_o)
   );

   initial forever #5 clk_i = ~clk_i;
   initial forever begin
      @(posedge clk_i);
      cyc++;
   end

   function automatic logic [31:0] data_of(input logic [31:0] a);
      return a ^ 32'hC3C3_0000;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   // DDR model and consumer act on the falling edge; the main sequence acts just after the rising edge.
   initial forever begin
      @(negedge clk_i);
      if (pop_pending) begin
         check("rdata", r_data_o, data_of(exp_addr));
         exp_addr++;
         words_seen++;
      end
      if (stall_pending) begin
         check("req_hold", ddr_req_o, 1);
         check("req_hold_addr", ddr_req_addr_o, stall_addr);
      end
      r_en_i      = man_ren || (cons_auto && r_avail_o);
      pop_pending = r_en_i && r_avail_o;
      if (pop_pending) pop_cyc_last = cyc + 1;
      ddr_rsp_valid_i = 1'b0;
      ddr_rsp_data_i  = '0;
      if (spur_rsp) begin
         ddr_rsp_valid_i = 1'b1;
         ddr_rsp_data_i  = 32'hBAD0_BAD0;
         spur_rsp        = 1'b0;
      end else if (pend.size() != 0 && pend[0].due <= cyc) begin
         ent             = pend.pop_front();
         ddr_rsp_valid_i = 1'b1;
         ddr_rsp_data_i  = data_of(ent.addr);
      end
      ddr_req_ready_i = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      stall_pending   = ddr_req_o && !ddr_req_ready_i;
      stall_addr      = ddr_req_addr_o;
      if (ddr_req_o && ddr_req_ready_i) begin
         pend.push_back('{addr: ddr_req_addr_o, due: cyc + int'($urandom_range(lat_min, lat_max))});
         req_log.push_back(ddr_req_addr_o);
         n_req++;
      end
   end

   task automatic start_job(input logic [31:0] b, input logic [15:0] n);
      exp_addr    = b;
      words_seen  = 0;
      n_req       = 0;
      req_log.delete();
      base_addr_i = b;
      num_words_i = n;
      start_i     = 1'b1;
      step();
      start_i     = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int budget);
      int k = 0;
      while (done_o !== 1'b1 && k < budget) begin
         step();
         k++;
      end
      check({tag, "_done"}, done_o, 1);
      check({tag, "_done_cyc"}, cyc, pop_cyc_last);
      step();
      check({tag, "_done_pulse"}, done_o, 0);
      check({tag, "_busy_fall"}, busy_o, 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_busy"}, busy_o, 0);
      check({tag, "_done"}, done_o, 0);
      check({tag, "_underflow"}, underflow_o, 0);
      check({tag, "_req"}, ddr_req_o, 0);
      check({tag, "_addr"}, ddr_req_addr_o, 0);
      check({tag, "_avail"}, r_avail_o, 0);
      check({tag, "_rdata"}, r_data_o, 0);
   endtask

   initial begin
      rst_ni      = 1'b0;
      start_i     = 1'b0;
      base_addr_i = '0;
      num_words_i = '0;
      #12;
      check_reset_outputs("reset");
      step();
      rst_ni = 1'b1;

      // Basic run: three words, one-cycle DDR, consumer pops whenever data is available.
      cons_auto = 1'b1;
      start_job(32'h100, 16'd3);
      check("basic_busy", busy_o, 1);
      check("basic_req", ddr_req_o, 1);
      check("basic_first_addr", ddr_req_addr_o, 32'h100);
      wait_done("basic", 50);
      check("basic_nreq", n_req, 3);
      for (int i = 0; i < 3; i++) check($sformatf("basic_req_addr%0d", i), req_log[i], 32'h100 + i);
      check("basic_words", words_seen, 3);

      // Credit cap: without pops only FifoDepth requests may be in flight or buffered.
      cons_auto = 1'b0;
      start_job(32'h200, 16'd10);
      repeat (20) step();
      check("credit_nreq4", n_req, 4);
      check("credit_req_low", ddr_req_o, 0);
      check("credit_avail", r_avail_o, 1);
      man_ren = 1'b1;
      step();
      man_ren = 1'b0;
      repeat (10) step();
      check("credit_nreq5", n_req, 5);
      check("credit_req_low2", ddr_req_o, 0);
      check("credit_words1", words_seen, 1);
      cons_auto = 1'b1;
      wait_done("credit", 200);
      check("credit_words", words_seen, 10);
      check("credit_nreq", n_req, 10);

      // Backpressure: random ready and latency, address run wraps past 0xFFFFFFFF.
      rdy_rand = 1'b1;
      lat_max  = 8;
      start_job(32'hFFFF_FFE0, 16'd64);
      wait_done("bp", 3000);
      check("bp_words", words_seen, 64);
      check("bp_nreq", n_req, 64);
      check("bp_last_addr", req_log[63], 32'h0000_001F);
      check("bp_underflow", underflow_o, 0);
      rdy_rand = 1'b0;
      lat_max  = 1;

      // Zero length: straight to DONE, no requests.
      start_job(32'h500, 16'd0);
      check("zero_busy", busy_o, 1);
      check("zero_done", done_o, 1);
      check("zero_req", ddr_req_o, 0);
      step();
      check("zero_busy_fall", busy_o, 0);
      check("zero_done_fall", done_o, 0);
      check("zero_nreq", n_req, 0);

      // Errors: pop while empty, then a response with nothing outstanding.
      man_ren = 1'b1;
      step();
      man_ren = 1'b0;
      step();
      check("err_ren", underflow_o, 1);
      repeat (3) step();
      check("err_sticky", underflow_o, 1);
      start_job(32'h600, 16'd0);
      check("err_cleared", underflow_o, 0);
      step();
      spur_rsp = 1'b1;
      step();
      step();
      check("err_spur", underflow_o, 1);
      check("err_spur_avail", r_avail_o, 0);

      // Reset mid-job with words buffered, then a clean short job.
      cons_auto = 1'b0;
      start_job(32'h300, 16'd8);
      repeat (4) step();
      check("rst_pre_avail", r_avail_o, 1);
      #1;
      rst_ni = 1'b0;
      pend.delete();
      #1;
      check_reset_outputs("rst_async");
      repeat (2) step();
      rst_ni    = 1'b1;
      cons_auto = 1'b1;
      start_job(32'h400, 16'd2);
      check("rst_job_addr", ddr_req_addr_o, 32'h400);
      wait_done("rst_job", 50);
      check("rst_job_words", words_seen, 2);
      check("rst_job_nreq", n_req, 2);
      check("rst_job_underflow", underflow_o, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/ddr_read_prefetcher.md
# ddr_read_prefetcher

Upstream feeder for `matrix_unit`: fetches a contiguous run of `ddr_data_t` words from the DDR read port and buffers them in a small FIFO. It serves them to `matrix_unit` with a fixed one-cycle read latency. It hides variable DDR latency behind a credit scheme, so the FIFO can never overflow, and it reports completion when the last word of a job has been consumed.

## Interface
Parameters:
- `FifoDepth`, default 4: buffer entries. Power of two, at least 2.
- `NumWordsW`, default 16: width of the job length count.

Ports (clock and reset first):
- `clk_i`  in  1  single clock.
- `rst_ni`  in  1  reset, asynchronous and active-low.
- `start_i`  in  1  launch job. Sampled only in IDLE.
- `base_addr_i`  in  `ddr_addr_t`  first word address. Captured on start.
- `num_words_i`  in  `NumWordsW`  job length in words. Captured on start.
- `busy_o`  out  1  job in progress.
- `done_o`  out  1  one-cycle pulse after the last word is consumed.
- `underflow_o`  out  1  sticky error: read while empty, or a response arrived with nothing outstanding.
- `ddr_req_o`  out  1  read request valid.
- `ddr_req_addr_o`  out  `ddr_addr_t`  request address.
- `ddr_req_ready_i`  in  1  DDR accepts the request this cycle.
- `ddr_rsp_valid_i`  in  1  response word valid. Responses return in order.
- `ddr_rsp_data_i`  in  `ddr_data_t`  response word.
- `r_avail_o`  out  1  FIFO non-empty.
- `r_en_i`  in  1  consumer pops a word (`matrix_unit.ddr_r_en_o`).
- `r_data_o`  out  `ddr_data_t`  popped word. Registered.

## Operation
States:
- **IDLE:** `busy_o=0`. `start_i=1` captures address and length, clears counters, and goes to FETCH. If length is 0, it goes to DONE instead.
- **FETCH:** issues requests while `issued < num_words` and `outstanding + occupancy < FifoDepth`. When `issued == num_words`, it goes to DRAIN.
- **DRAIN:** no new requests. When `consumed == num_words`, it goes to DONE.
- **DONE:** `done_o=1` for exactly one cycle, then IDLE.

Request rules:
- A request is accepted when `ddr_req_o && ddr_req_ready_i`.
- On acceptance, `ddr_req_addr_o` increments by 1 and `issued++`.
- `ddr_req_o` and `ddr_req_addr_o` are held stable until accepted.

Response and pop rules:
- A response pushes into the FIFO.
- `r_en_i` with the FIFO non-empty pops the head into `r_data_o` and increments `consumed`.
- Push and pop in the same cycle are both performed; occupancy is unchanged.
- `r_en_i` with the FIFO empty: no pop, `r_data_o` holds, `underflow_o` is set.
- A response with `outstanding == 0` is dropped and sets `underflow_o`.

Other rules:
- `start_i` outside IDLE is ignored.
- `underflow_o` clears only on reset or on an accepted start.
- Counter arithmetic is unsigned. `outstanding` and occupancy widths are `$clog2(FifoDepth)+1`. Address increment wraps modulo 2^width.

## Timing
- Reset values: `busy_o=0`, `done_o=0`, `underflow_o=0`, `ddr_req_o=0`, `ddr_req_addr_o=0`, `r_avail_o=0`, `r_data_o=0`. FIFO empty, state IDLE.
- Assertion of reset mid-job aborts immediately. In-flight DDR responses after reset release are treated as unexpected (underflow).
- `start_i` high at edge N: `busy_o` and `ddr_req_o` are high from N+1.
- The request issued at N+1 carries `base_addr_i`.
- Response at edge M: `r_avail_o` is high from M+1. There is no bypass.
- `r_en_i` at edge K: `r_data_o` is valid from K+1 until the next pop.
- With zero-latency DDR and `r_en_i` held high, throughput is 1 word per cycle.
- Last pop at edge L: the state is DONE from L+1, so `done_o=1` in cycle L+1. `busy_o` stays high through DONE and falls at L+2.
- Credit check uses registered `outstanding` and occupancy. A pop in the same cycle does not grant a credit until the next cycle.

## Structure
- `config_pkg` holds `ddr_addr_t` (new, 32-bit), the existing `ddr_data_t`, and the `FifoDepth` default.
- `dv_pkg` gains `random_ddr_latency()` for benches.
- One sub-module, `sync_fifo`: parameterised width/depth, with push/pop/full/empty/count and an asynchronous active-low reset.
- The FSM and counters stay in `ddr_read_prefetcher`.

## Test plan
- **Basic run:** base 0x100, length 3, DDR ready always, response 1 cycle after request, `r_en_i` whenever avail → requests 0x100, 0x101, 0x102. `r_data_o` sequence matches the DDR model. `done_o` pulses once, one cycle after the third pop.
- **Credit cap:** length 10, consumer never reads → exactly 4 requests accepted, `ddr_req_o` then low. One pop → exactly one more request.
- **Backpressure:** `ddr_req_ready_i` random 50%, DDR latency random 1–8 cycles, length 64 → all 64 words delivered in order with no drops, and `underflow_o=0`.
- **Zero length:** length 0 → no requests, `done_o` pulses at cycle N+1, `busy_o` high for one cycle only.
- **Errors:** `r_en_i` in IDLE, or a spurious `ddr_rsp_valid_i` → `underflow_o=1` and sticky; cleared by the next accepted start.
- **Reset mid-job:** `rst_ni` low during FETCH with 2 words buffered → all outputs at reset values asynchronously. A following start with length 2 completes normally.
